rgb_entry_memory: RTL and testbench
===================================

Name: rgb_entry_memory

Overview:
- Keypad-driven entry memory for multi-channel colour values. It is the parametrised successor of the fixed 3-digit / 3-channel RGB digit store.
- Collects decimal digits on strobed key codes and supports backspace, commit and clear-all.
- Range-checks each committed value and stores it per channel.
- Flags full once every channel holds a value. Sits between the keypad decoder and the PWM/display stage.

Parameters:
- NDIG, 3, max decimal digits per entry (1..4)
- NCH, 3, number of channels (R,G,B default)
- MAXV, 255, max legal committed value
- VW, 8, width of each stored channel value (must hold MAXV)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- digito  in  5  key code: 0x0-0x9 digit, 0xA enter, 0xB backspace, 0xC clear-all; all others ignored
- cambio_digito  in  1  key strobe, level; one key per rising edge
- entry_bcd  out  4*NDIG  digits being typed; [3:0] = units
- entry_cnt  out  3  digits currently held (0..NDIG)
- ch_idx  out  clog2(NCH)+1  channel receiving the next commit
- ch_value  out  NCH*VW  committed values; channel 0 in [VW-1:0]
- ch_valid  out  NCH  per-channel committed flag
- RGB_full  out  1  all NCH channels committed
- err  out  1  one-cycle pulse on a rejected commit

Behaviour:
- Reset (async, any time, including mid-entry): all outputs and internal state are 0. This includes the strobe history register.
- Key acceptance
  - A key is accepted on the clk edge where cambio_digito=1 and the registered previous strobe is 0.
  - A strobe held high for many cycles is accepted once.
  - All outputs update on that same edge (0-cycle latency from the acceptance edge). err is high only in the following cycle.
- Digit (0..9), when entry_cnt<NDIG and RGB_full=0:
  - entry_bcd shifts left by 4 bits; the new digit enters [3:0]; entry_cnt+1.
  - Digits beyond NDIG are ignored.
  - Leading zeros count as digits.
- Backspace (0xB):
  - entry_cnt>0: entry_bcd shifts right by 4 bits with zero fill; entry_cnt-1.
  - entry_cnt=0: no-op.
- Enter (0xA):
  - entry_cnt=0 or RGB_full=1: no-op, no err.
  - Otherwise compute val = decimal value of entry_bcd.
  - val<=MAXV: ch_value[ch_idx]<=val, ch_valid[ch_idx]<=1, ch_idx+1.
  - val>MAXV: err pulses, the channel is unchanged, ch_idx is unchanged.
  - In both cases entry_bcd and entry_cnt clear.
- RGB_full = &ch_valid. Once full, digits, backspace and enter are ignored; ch_idx holds at NCH.
- Clear-all (0xC): synchronous equivalent of reset, except the strobe history register, which keeps tracking the strobe. Accepted even when full.
- Ignored codes (0xD-0x1F) do not change state but do consume the strobe edge.
- Width rules: the BCD-to-binary result is 14 bits wide (covers 9999). The comparison against MAXV is done at that width; truncation to VW happens only after the check passes.

Decomposition:
- Package rge_pkg holds the key-code constants: KEY_ENTER=5'hA, KEY_BS=5'hB, KEY_CLR=5'hC.
- One sub-module, bcd_to_bin: combinational, parametrised by NDIG, computes Σ digit·10^i.
- The FSM is the implicit counter pair (entry_cnt, ch_idx) with states ENTRY and FULL. FULL is equivalent to RGB_full=1.

Test Plan:
- Strobes 1,2,8,A (each 1 cycle high, 3 cycles low) -> entry_bcd 0x128 before enter; after enter ch_value[0]=128, ch_valid=001, ch_idx=1, entry_cnt=0.
- Strobes 2,5,6,A -> err=1 for exactly one cycle, ch_valid unchanged, entry_cnt=0.
- Strobes 9,9,B,7,A -> entry_bcd 0x9 after backspace; commits 97. Also: 1,2,3,4 -> the 4th digit is ignored, entry_bcd=0x123.
- Commit 10, 20, 30 -> RGB_full=1, ch_value={30,20,10}. Then 5,A -> no change. Then C -> all outputs 0.
- Hold cambio_digito high 20 cycles with digito=3 -> exactly one digit accepted, entry_cnt=1. Code 0xF strobed -> no state change.
- Assert rst mid-entry (entry_cnt=2, ch_valid=011) between clock edges -> all outputs 0 immediately, without waiting for a clock edge. Next key is accepted normally.

Source files
------------

// File: rtl/rge_pkg.sv
// Shared key codes and FSM state type for the colour entry memory.
package rge_pkg;

  localparam logic [4:0] KEY_ENTER = 5'hA;
  localparam logic [4:0] KEY_BS    = 5'hB;
  localparam logic [4:0] KEY_CLR   = 5'hC;

  // Width of the BCD-to-binary result: 9999 still fits.
  localparam int BIN_W = 14;

  typedef enum logic {
    ENTRY = 1'b0,
    FULL  = 1'b1
  } rge_state_t;

endpackage

// File: rtl/rgb_entry_memory_bcd_to_bin.sv
// Combinational BCD to binary conversion: sum of digit * 10^i, [3:0] = units.
module bcd_to_bin
  import rge_pkg::*;
#(
  parameter int NDIG = 3
) (
  input  logic [4*NDIG-1:0] bcd,
  output logic [BIN_W-1:0]  bin
);

  // Horner evaluation from the most significant digit down.
  always_comb begin
    bin = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      bin = bin * BIN_W'(10) + BIN_W'(bcd[4*i +: 4]);
    end
  end

endmodule

// File: rtl/rgb_entry_memory.sv
// Keypad entry memory: collects decimal digits, range-checks each committed
// value and stores it in the next free channel; flags full when all are set.
//
// state | meaning
// ENTRY | accepting digits, backspace and enter for channel ch_idx
// FULL  | every channel committed; only clear-all is honoured
module rgb_entry_memory
  import rge_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int NCH  = 3,
  parameter int MAXV = 255,
  parameter int VW   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               digito,
  input  logic                     cambio_digito,
  output logic [4*NDIG-1:0]        entry_bcd,
  output logic [2:0]               entry_cnt,
  output logic [$clog2(NCH):0]     ch_idx,
  output logic [NCH*VW-1:0]        ch_value,
  output logic [NCH-1:0]           ch_valid,
  output logic                     RGB_full,
  output logic                     err
);

  localparam int CIW = $clog2(NCH) + 1;
  localparam int BW  = 4 * NDIG;
  localparam logic [BIN_W-1:0] MAXV_W = BIN_W'(MAXV);
  localparam logic [2:0]       NDIG_C = 3'(NDIG);

  rge_state_t         state;
  logic               strobe_q;
  logic               key_acc;
  logic               is_digit;
  logic [NCH-1:0]     ch_sel;
  logic [NCH-1:0]     valid_after;
  logic [BIN_W-1:0]   bin_val;

  bcd_to_bin #(.NDIG(NDIG)) u_bcd_to_bin (
    .bcd (entry_bcd),
    .bin (bin_val)
  );

  // Key edge detect and one-hot select of the channel taking the next commit.
  always_comb begin
    key_acc  = cambio_digito & ~strobe_q;
    is_digit = (digito < 5'd10);
    ch_sel   = '0;
    for (int c = 0; c < NCH; c++) begin
      ch_sel[c] = (ch_idx == CIW'(c));
    end
    valid_after = ch_valid | ch_sel;
  end

  assign RGB_full = (state == FULL);

  // Key handling FSM; the strobe history survives clear-all but not reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ENTRY;
      strobe_q  <= 1'b0;
      entry_bcd <= '0;
      entry_cnt <= '0;
      ch_idx    <= '0;
      ch_value  <= '0;
      ch_valid  <= '0;
      err       <= 1'b0;
    end else begin
      strobe_q <= cambio_digito;
      err      <= 1'b0;
      if (key_acc) begin
        if (digito == KEY_CLR) begin
          state     <= ENTRY;
          entry_bcd <= '0;
          entry_cnt <= '0;
          ch_idx    <= '0;
          ch_value  <= '0;
          ch_valid  <= '0;
        end else if (state == ENTRY) begin
          if (is_digit) begin
            if (entry_cnt < NDIG_C) begin
              entry_bcd <= (entry_bcd << 4) | BW'(digito[3:0]);
              entry_cnt <= entry_cnt + 3'd1;
            end
          end else if (digito == KEY_BS) begin
            if (entry_cnt != 3'd0) begin
              entry_bcd <= entry_bcd >> 4;
              entry_cnt <= entry_cnt - 3'd1;
            end
          end else if (digito == KEY_ENTER && entry_cnt != 3'd0) begin
            entry_bcd <= '0;
            entry_cnt <= '0;
            // Range check at full conversion width before truncating to VW.
            if (bin_val <= MAXV_W) begin
              for (int c = 0; c < NCH; c++) begin
                if (ch_sel[c]) ch_value[c*VW +: VW] <= bin_val[VW-1:0];
              end
              ch_valid <= valid_after;
              ch_idx   <= ch_idx + CIW'(1);
              if (&valid_after) state <= FULL;
            end else begin
              err <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_entry_memory.sv
// Scoreboard bench for rgb_entry_memory (default parameters).
module tb_rgb_entry_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  digito = 5'd0;
  logic        cambio_digito = 1'b0;
  logic [11:0] entry_bcd;
  logic [2:0]  entry_cnt;
  logic [2:0]  ch_idx;
  logic [23:0] ch_value;
  logic [2:0]  ch_valid;
  logic        RGB_full;
  logic        err;

  rgb_entry_memory dut (
    .clk           (clk),
    .rst           (rst),
    .digito        (digito),
    .cambio_digito (cambio_digito),
    .entry_bcd     (entry_bcd),
    .entry_cnt     (entry_cnt),
    .ch_idx        (ch_idx),
    .ch_value      (ch_value),
    .ch_valid      (ch_valid),
    .RGB_full      (RGB_full),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] bcd;
    logic [2:0]  cnt;
    logic [2:0]  idx;
    logic [23:0] val;
    logic [2:0]  vld;
    logic        full;
    logic        err;
  } snap_t;

  snap_t q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    key_no = 0;

  function automatic snap_t actual();
    snap_t a;
    a = '{bcd: entry_bcd, cnt: entry_cnt, idx: ch_idx, val: ch_value,
          vld: ch_valid, full: RGB_full, err: err};
    return a;
  endfunction

  task automatic check(input string name, input snap_t e);
    snap_t a;
    a = actual();
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got bcd=%h cnt=%0d idx=%0d val=%h vld=%b full=%b err=%b, want bcd=%h cnt=%0d idx=%0d val=%h vld=%b full=%b err=%b",
               name, a.bcd, a.cnt, a.idx, a.val, a.vld, a.full, a.err,
               e.bcd, e.cnt, e.idx, e.val, e.vld, e.full, e.err);
    end
  endtask

  // Push the hand-computed expected state, then strobe the key.
  task automatic key(input logic [4:0] code, input logic [11:0] bcd,
                     input logic [2:0] cnt, input logic [2:0] idx,
                     input logic [23:0] val, input logic [2:0] vld,
                     input logic e, input int hold = 1);
    snap_t s;
    s = '{bcd: bcd, cnt: cnt, idx: idx, val: val, vld: vld, full: &vld, err: e};
    q.push_back(s);
    @(negedge clk);
    digito = code;
    cambio_digito = 1'b1;
    repeat (hold) @(negedge clk);
    cambio_digito = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: detect accepted strobes from the pins, compare after the edge,
  // and check that err has dropped one cycle later.
  initial begin : monitor
    logic prev;
    logic acc;
    snap_t e;
    snap_t z;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      acc  = cambio_digito & ~prev & ~rst;
      prev = rst ? 1'b0 : cambio_digito;
      if (acc) begin
        @(negedge clk);
        key_no++;
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_key %0d: got an accepted key, want none queued", key_no);
        end else begin
          e = q.pop_front();
          check($sformatf("key%0d", key_no), e);
          @(negedge clk);
          z = e;
          z.err = 1'b0;
          check($sformatf("key%0d_err_drop", key_no), z);
        end
      end
    end
  end

  initial begin
    snap_t zero;
    int    budget;
    zero = '0;
    repeat (2) @(negedge clk);
    check("reset_held", zero);
    rst = 1'b0;
    @(negedge clk);
    check("reset_released", zero);

    // 1,2,8,Enter -> 128 in channel 0
    key(5'h1, 12'h001, 3'd1, 3'd0, 24'h000000, 3'b000, 1'b0);
    key(5'h2, 12'h012, 3'd2, 3'd0, 24'h000000, 3'b000, 1'b0);
    key(5'h8, 12'h128, 3'd3, 3'd0, 24'h000000, 3'b000, 1'b0);
    key(5'hA, 12'h000, 3'd0, 3'd1, 24'h000080, 3'b001, 1'b0);
    // 256 is out of range: err pulse, channel untouched
    key(5'h2, 12'h002, 3'd1, 3'd1, 24'h000080, 3'b001, 1'b0);
    key(5'h5, 12'h025, 3'd2, 3'd1, 24'h000080, 3'b001, 1'b0);
    key(5'h6, 12'h256, 3'd3, 3'd1, 24'h000080, 3'b001, 1'b0);
    key(5'hA, 12'h000, 3'd0, 3'd1, 24'h000080, 3'b001, 1'b1);
    // 9,9,BS,7,Enter -> 97 in channel 1
    key(5'h9, 12'h009, 3'd1, 3'd1, 24'h000080, 3'b001, 1'b0);
    key(5'h9, 12'h099, 3'd2, 3'd1, 24'h000080, 3'b001, 1'b0);
    key(5'hB, 12'h009, 3'd1, 3'd1, 24'h000080, 3'b001, 1'b0);
    key(5'h7, 12'h097, 3'd2, 3'd1, 24'h000080, 3'b001, 1'b0);
    key(5'hA, 12'h000, 3'd0, 3'd2, 24'h006180, 3'b011, 1'b0);
    // fourth digit ignored, then clear-all mid-entry
    key(5'h1, 12'h001, 3'd1, 3'd2, 24'h006180, 3'b011, 1'b0);
    key(5'h2, 12'h012, 3'd2, 3'd2, 24'h006180, 3'b011, 1'b0);
    key(5'h3, 12'h123, 3'd3, 3'd2, 24'h006180, 3'b011, 1'b0);
    key(5'h4, 12'h123, 3'd3, 3'd2, 24'h006180, 3'b011, 1'b0);
    key(5'hC, 12'h000, 3'd0, 3'd0, 24'h000000, 3'b000, 1'b0);
    // commit 10, 20, 30 -> full
    key(5'h1, 12'h001, 3'd1, 3'd0, 24'h000000, 3'b000, 1'b0);
    key(5'h0, 12'h010, 3'd2, 3'd0, 24'h000000, 3'b000, 1'b0);
    key(5'hA, 12'h000, 3'd0, 3'd1, 24'h00000A, 3'b001, 1'b0);
    key(5'h2, 12'h002, 3'd1, 3'd1, 24'h00000A, 3'b001, 1'b0);
    key(5'h0, 12'h020, 3'd2, 3'd1, 24'h00000A, 3'b001, 1'b0);
    key(5'hA, 12'h000, 3'd0, 3'd2, 24'h00140A, 3'b011, 1'b0);
    key(5'h3, 12'h003, 3'd1, 3'd2, 24'h00140A, 3'b011, 1'b0);
    key(5'h0, 12'h030, 3'd2, 3'd2, 24'h00140A, 3'b011, 1'b0);
    key(5'hA, 12'h000, 3'd0, 3'd3, 24'h1E140A, 3'b111, 1'b0);
    // while full: digit, enter, backspace ignored; clear-all honoured
    key(5'h5, 12'h000, 3'd0, 3'd3, 24'h1E140A, 3'b111, 1'b0);
    key(5'hA, 12'h000, 3'd0, 3'd3, 24'h1E140A, 3'b111, 1'b0);
    key(5'hB, 12'h000, 3'd0, 3'd3, 24'h1E140A, 3'b111, 1'b0);
    key(5'hC, 12'h000, 3'd0, 3'd0, 24'h000000, 3'b000, 1'b0);
    // boundary 255 accepted; leading zeros 007 -> 7
    key(5'h2, 12'h002, 3'd1, 3'd0, 24'h000000, 3'b000, 1'b0);
    key(5'h5, 12'h025, 3'd2, 3'd0, 24'h000000, 3'b000, 1'b0);
    key(5'h5, 12'h255, 3'd3, 3'd0, 24'h000000, 3'b000, 1'b0);
    key(5'hA, 12'h000, 3'd0, 3'd1, 24'h0000FF, 3'b001, 1'b0);
    key(5'h0, 12'h000, 3'd1, 3'd1, 24'h0000FF, 3'b001, 1'b0);
    key(5'h0, 12'h000, 3'd2, 3'd1, 24'h0000FF, 3'b001, 1'b0);
    key(5'h7, 12'h007, 3'd3, 3'd1, 24'h0000FF, 3'b001, 1'b0);
    key(5'hA, 12'h000, 3'd0, 3'd2, 24'h0007FF, 3'b011, 1'b0);
    // enter and backspace with an empty entry are no-ops
    key(5'hA, 12'h000, 3'd0, 3'd2, 24'h0007FF, 3'b011, 1'b0);
    key(5'hB, 12'h000, 3'd0, 3'd2, 24'h0007FF, 3'b011, 1'b0);
    // strobe held 20 cycles counts once; ignored code consumes the edge
    key(5'h3, 12'h003, 3'd1, 3'd2, 24'h0007FF, 3'b011, 1'b0, 20);
    key(5'hF, 12'h003, 3'd1, 3'd2, 24'h0007FF, 3'b011, 1'b0);
    key(5'h4, 12'h034, 3'd2, 3'd2, 24'h0007FF, 3'b011, 1'b0);

    // asynchronous reset between edges, mid-entry
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", zero);
    #1 rst = 1'b0;
    key(5'h5, 12'h005, 3'd1, 3'd0, 24'h000000, 3'b000, 1'b0);

    budget = 0;
    while (q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d expected responses never observed, want 0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
